spi_master_cfg: RTL and testbench
=================================

// Module: spi_master_cfg
// PURPOSE
//  Parametrised SPI master replacing the fixed 16-bit, mode-0, single-SS controller.
//  Runtime SPI mode (CPOL/CPHA), runtime clock divider, MSB/LSB-first and NUM_SS selects.
//  Sits behind the wb_spi register slave; one frame of DATA_W bits per start pulse.
// PARAMETERS
//  DATA_W  16  frame length in bits (>=2)
//  DIV_W   8   width of clk_div input
//  NUM_SS  4   number of active-low slave-select lines (>=1)
// PORTS
//  clk       in   1       system clock, rising edge
//  rst       in   1       reset, asynchronous, active-low
//  start     in   1       request frame; honoured only when busy=0
//  data_in   in   DATA_W  frame to transmit, latched on accepted start
//  clk_div   in   DIV_W   SCK half-period = clk_div+1 clk cycles, latched on start
//  cpol      in   1       SCK idle level
//  cpha      in   1       0: sample leading edge; 1: sample trailing edge
//  lsb_first in   1       1: shift LSB first, latched on start
//  ss_sel    in   log2(NUM_SS) (min 1)  slave index, latched on start
//  miso      in   1       serial in
//  mosi      out  1       serial out
//  sck       out  1       serial clock
//  ss_n      out  NUM_SS  slave selects, active-low
//  data_out  out  DATA_W  last received frame
//  busy      out  1       frame in progress
//  done      out  1       one-cycle pulse, data_out valid
// BEHAVIOUR
//  Reset (rst=0, async): state IDLE, sck=0, mosi=0, ss_n=all 1, busy=0, done=0, data_out=0.
//  Mid-frame reset aborts immediately; data_out keeps reset value, no done pulse.
//  Tick: divider counts 0..div_q; tick when count==div_q, count then reloads 0.
//  FSM: IDLE -> LEAD -> XFER -> TRAIL -> IDLE.
//   IDLE : sck follows cpol input each cycle. start=1 -> latch data_in, clk_div, cpol, cpha,
//          lsb_first, ss_sel; assert selected ss_n; go LEAD; busy=1 from next cycle.
//   LEAD : one half-period (1 tick). CPHA=0: first bit driven on mosi on entry.
//   XFER : 2*DATA_W ticks, sck toggles each tick (edge 1 = leading).
//          CPHA=0: sample miso on leading edges, shift mosi on trailing (not after last).
//          CPHA=1: shift mosi on leading edges, sample miso on trailing.
//          After last edge sck is back at cpol_q.
//   TRAIL: one half-period with SS still asserted; on tick: ss_n all 1, data_out <= shift
//          register, done=1 for that cycle, state IDLE. busy=0 from next cycle.
//  Frame length: 2+2*DATA_W ticks, i.e. (2*DATA_W+2)*(clk_div+1) cycles start->done, +1.
//  Bit order: lsb_first=0 transmits data_in[DATA_W-1] first, received bit placed MSB-first;
//   lsb_first=1 mirrors both directions. data_out bit order matches data_in bit order.
//  start while busy=1: ignored, no queueing. start in same cycle as done: ignored (busy still 1).
//  clk_div=0: half-period = 1 clk; sck toggles every cycle; must still be correct.
//  ss_sel >= NUM_SS: frame runs, no ss_n asserted.
//  Changes on cpol/cpha/clk_div/lsb_first during a frame have no effect.
//  mosi holds last driven bit after frame until next frame drives new first bit.
//  All outputs registered; no combinational path input->output.
// STRUCTURE
//  Package spi_pkg: FSM state encoding (IDLE/LEAD/XFER/TRAIL), SPI mode localparams
//   (MODE0..MODE3 as {cpol,cpha}), clog2 helper for ss_sel width.
//  Sub-module spi_clkgen: divider counter, tick output, enable/clear; instantiated once.
//  Top holds FSM, edge counter (clog2(2*DATA_W+1) bits), shift register, SS decoder.
// TESTING
//  1 Mode 0, DATA_W=16, clk_div=1, data_in=16'hA5C3, slave loopback mosi->miso
//    -> data_out=16'hA5C3, done once, start->done = 34*2+1 cycles, ss_n[0] low throughout.
//  2 All four modes vs. SPI slave model returning 16'h3C5A, slave checks its edge
//    -> master data_out=16'h3C5A, slave received data_in each mode; sck idles at cpol.
//  3 lsb_first=1, data_in=16'h0001 -> first mosi bit=1, remaining 15 bits 0; loopback
//    data_out=16'h0001.
//  4 start pulsed every cycle during frame, ss_sel=2 -> exactly one frame, ss_n=4'b1011,
//    next frame starts only after busy falls.
//  5 rst low at edge 10 of a frame -> same-cycle ss_n=4'hF, sck=0, busy=0, no done;
//    next frame after release completes normally.
//  6 clk_div=0 and clk_div=255 -> sck period 2 and 512 clks, correct data both.

Source files
------------

// File: rtl/spi_pkg.sv
// Shared types for the configurable SPI master: FSM state encoding, SPI mode
// constants and the slave-select width helper.
package spi_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_LEAD  = 2'd1,
    ST_XFER  = 2'd2,
    ST_TRAIL = 2'd3
  } state_t;

  // SPI modes encoded as {cpol, cpha}
  localparam logic [1:0] MODE0 = 2'b00;
  localparam logic [1:0] MODE1 = 2'b01;
  localparam logic [1:0] MODE2 = 2'b10;
  localparam logic [1:0] MODE3 = 2'b11;

  // ceil(log2(n)), never below 1 so a single-slave build still has a select bit
  function automatic int clog2_min1(input int n);
    int w;
    w = 1;
    for (int i = 1; i < 31; i++) begin
      if ((1 << i) < n) w = i + 1;
    end
    return w;
  endfunction

endpackage

// File: rtl/spi_clkgen.sv
// SCK half-period generator: counts 0..div while enabled and flags a tick on
// the last count, then reloads zero.
module spi_clkgen #(
  parameter int DIV_W = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             clr,
  input  logic [DIV_W-1:0] div,
  output logic             tick
);

  logic [DIV_W-1:0] cnt_reg;

  assign tick = en && (cnt_reg == div);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt_reg <= '0;
    end else if (clr || !en || tick) begin
      cnt_reg <= '0;
    end else begin
      cnt_reg <= cnt_reg + 1'b1;
    end
  end

endmodule

// File: rtl/spi_master_cfg.sv
// SPI master with runtime CPOL/CPHA, clock divider, bit order and slave select.
// One DATA_W-bit full-duplex frame per accepted start pulse.
module spi_master_cfg
  import spi_pkg::*;
#(
  parameter int DATA_W = 16,
  parameter int DIV_W  = 8,
  parameter int NUM_SS = 4,
  localparam int SS_W  = clog2_min1(NUM_SS)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [DATA_W-1:0] data_in,
  input  logic [DIV_W-1:0]  clk_div,
  input  logic              cpol,
  input  logic              cpha,
  input  logic              lsb_first,
  input  logic [SS_W-1:0]   ss_sel,
  input  logic              miso,
  output logic              mosi,
  output logic              sck,
  output logic [NUM_SS-1:0] ss_n,
  output logic [DATA_W-1:0] data_out,
  output logic              busy,
  output logic              done
);

  localparam int EDGES = 2 * DATA_W;
  localparam int EC_W  = $clog2(EDGES + 1);

  state_t            state_reg;
  logic [DIV_W-1:0]  div_reg;
  logic              cpha_reg;
  logic              lsb_reg;
  logic [DATA_W-1:0] tx_reg;
  logic [DATA_W-1:0] rx_reg;
  logic [EC_W-1:0]   edge_reg;

  logic              tick;
  logic              accept;
  logic              leading;
  logic              last_edge;
  logic              shift_ev;
  logic              sample_ev;
  logic [DATA_W-1:0] data_in_rev;
  logic [DATA_W-1:0] rx_rev;
  logic [DATA_W-1:0] tx_load;
  logic [NUM_SS-1:0] ss_dec;

  // Bit order is handled by mirroring at load and unload; the shifter is always MSB-first.
  for (genvar gi = 0; gi < DATA_W; gi++) begin : g_rev
    assign data_in_rev[gi] = data_in[DATA_W-1-gi];
    assign rx_rev[gi]      = rx_reg[DATA_W-1-gi];
  end

  // Out-of-range selects match no line, so the frame runs with every ss_n high.
  for (genvar gi = 0; gi < NUM_SS; gi++) begin : g_ss
    assign ss_dec[gi] = (ss_sel == SS_W'(gi));
  end

  assign tx_load   = lsb_first ? data_in_rev : data_in;
  assign accept    = start && (state_reg == ST_IDLE) && !busy;
  assign leading   = ~edge_reg[0];
  assign last_edge = (edge_reg == EC_W'(EDGES - 1));
  assign shift_ev  = cpha_reg ? leading : (!leading && !last_edge);
  assign sample_ev = cpha_reg ? !leading : leading;

  spi_clkgen #(
    .DIV_W (DIV_W)
  ) u_clkgen (
    .clk  (clk),
    .rst  (rst),
    .en   (state_reg != ST_IDLE),
    .clr  (accept),
    .div  (div_reg),
    .tick (tick)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_reg <= ST_IDLE;
      div_reg   <= '0;
      cpha_reg  <= 1'b0;
      lsb_reg   <= 1'b0;
      tx_reg    <= '0;
      rx_reg    <= '0;
      edge_reg  <= '0;
      sck       <= 1'b0;
      mosi      <= 1'b0;
      ss_n      <= '1;
      data_out  <= '0;
      busy      <= 1'b0;
      done      <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state_reg)
        ST_IDLE: begin
          sck <= cpol;
          // busy lingers through the done cycle so a start coincident with done is dropped
          if (accept) begin
            div_reg   <= clk_div;
            cpha_reg  <= cpha;
            lsb_reg   <= lsb_first;
            ss_n      <= ~ss_dec;
            busy      <= 1'b1;
            edge_reg  <= '0;
            rx_reg    <= '0;
            state_reg <= ST_LEAD;
            if (cpha) begin
              tx_reg <= tx_load;
            end else begin
              mosi   <= tx_load[DATA_W-1];
              tx_reg <= tx_load << 1;
            end
          end else begin
            busy <= 1'b0;
          end
        end
        ST_LEAD: begin
          if (tick) state_reg <= ST_XFER;
        end
        ST_XFER: begin
          if (tick) begin
            sck      <= ~sck;
            edge_reg <= edge_reg + 1'b1;
            if (shift_ev) begin
              mosi   <= tx_reg[DATA_W-1];
              tx_reg <= tx_reg << 1;
            end
            if (sample_ev) rx_reg <= {rx_reg[DATA_W-2:0], miso};
            if (last_edge) state_reg <= ST_TRAIL;
          end
        end
        ST_TRAIL: begin
          if (tick) begin
            ss_n      <= '1;
            data_out  <= lsb_reg ? rx_rev : rx_reg;
            done      <= 1'b1;
            state_reg <= ST_IDLE;
          end
        end
        default: state_reg <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_spi_master_cfg.sv
// Directed bench for spi_master_cfg: loopback and SPI-slave-model frames in
// all modes, bit order, start filtering, mid-frame reset and divider extremes.
module tb_spi_master_cfg;
  import spi_pkg::*;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        start = 1'b0;
  logic [15:0] data_in = '0;
  logic [7:0]  clk_div = '0;
  logic        cpol = 1'b0;
  logic        cpha = 1'b0;
  logic        lsb_first = 1'b0;
  logic [1:0]  ss_sel = '0;
  logic        miso;
  logic        mosi;
  logic        sck;
  logic [3:0]  ss_n;
  logic [15:0] data_out;
  logic        busy;
  logic        done;

  int checks = 0;
  int failures = 0;
  int done_cnt = 0;

  // slave model state
  logic        loopback = 1'b1;
  logic        s_miso = 1'b0;
  logic        sl_cpol = 1'b0;
  logic        sl_cpha = 1'b0;
  logic [15:0] s_tx_word = 16'h3C5A;
  logic [15:0] s_tx = '0;
  logic [15:0] s_rx = '0;
  int          s_edges = 0;

  logic [1:0]  modes [4] = '{MODE0, MODE1, MODE2, MODE3};
  logic [15:0] words [4] = '{16'h1234, 16'hBEEF, 16'h0F0F, 16'hC001};

  always #5 clk = ~clk;

  assign miso = loopback ? mosi : s_miso;

  spi_master_cfg #(
    .DATA_W (16),
    .DIV_W  (8),
    .NUM_SS (4)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .data_in   (data_in),
    .clk_div   (clk_div),
    .cpol      (cpol),
    .cpha      (cpha),
    .lsb_first (lsb_first),
    .ss_sel    (ss_sel),
    .miso      (miso),
    .mosi      (mosi),
    .sck       (sck),
    .ss_n      (ss_n),
    .data_out  (data_out),
    .busy      (busy),
    .done      (done)
  );

  always @(posedge clk) if (done === 1'b1) done_cnt++;

  // SPI slave on ss_n[0]: samples on its mode's sample edge, drives on the other
  always @(negedge ss_n[0]) begin
    s_tx    = s_tx_word;
    s_rx    = '0;
    s_edges = 0;
    if (!sl_cpha) begin
      s_miso = s_tx[15];
      s_tx   = s_tx << 1;
    end
  end

  always @(sck) begin
    if (ss_n[0] === 1'b0) begin
      s_edges++;
      if ((sck !== sl_cpol) ^ sl_cpha) begin
        s_rx = {s_rx[14:0], mosi};
      end else begin
        s_miso = s_tx[15];
        s_tx   = s_tx << 1;
      end
    end
  end

  task automatic run_frame(input logic [15:0] d, input logic [7:0] div, input logic pol,
                           input logic pha, input logic lsb, input logic [1:0] sel,
                           output int cyc, output int per, output int ss_bad);
    logic [3:0] ss_exp;
    logic       prev;
    int         r1, r2;
    ss_exp      = 4'b1111;
    ss_exp[sel] = 1'b0;
    @(posedge clk); #1;
    data_in = d; clk_div = div; cpol = pol; cpha = pha; lsb_first = lsb; ss_sel = sel;
    sl_cpol = pol; sl_cpha = pha;
    @(posedge clk); #1;
    start = 1'b1; cyc = 0; ss_bad = 0; r1 = -1; r2 = -1; prev = sck;
    while (cyc < 20000) begin
      @(posedge clk); #1;
      cyc++;
      start = 1'b0;
      if (done === 1'b1) break;
      if (ss_n !== ss_exp) ss_bad++;
      if (sck === 1'b1 && prev === 1'b0) begin
        if (r1 < 0) r1 = cyc;
        else if (r2 < 0) r2 = cyc;
      end
      prev = sck;
    end
    per = r2 - r1;
    checks++;
    if (done !== 1'b1) begin
      failures++;
      $display("FAIL frame_timeout done=%b required=1 after %0d cycles", done, cyc);
    end
  endtask

  task automatic test_reset;
    repeat (3) @(posedge clk);
    #1;
    checks++; if (sck !== 1'b0) begin failures++; $display("FAIL rst_sck got=%b exp=0", sck); end
    checks++; if (mosi !== 1'b0) begin failures++; $display("FAIL rst_mosi got=%b exp=0", mosi); end
    checks++; if (ss_n !== 4'hF) begin failures++; $display("FAIL rst_ss_n got=%h exp=f", ss_n); end
    checks++; if (busy !== 1'b0) begin failures++; $display("FAIL rst_busy got=%b exp=0", busy); end
    checks++; if (done !== 1'b0) begin failures++; $display("FAIL rst_done got=%b exp=0", done); end
    checks++; if (data_out !== 16'h0) begin failures++; $display("FAIL rst_data_out got=%h exp=0000", data_out); end
    rst = 1'b1;
    cpol = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    checks++; if (sck !== 1'b1) begin failures++; $display("FAIL idle_sck_follows_cpol got=%b exp=1", sck); end
    cpol = 1'b0;
    repeat (2) @(posedge clk);
    #1;
  endtask

  task automatic test_mode0_loopback;
    int cyc, per, bad, d0;
    loopback = 1'b1;
    d0 = done_cnt;
    run_frame(16'hA5C3, 8'd1, 1'b0, 1'b0, 1'b0, 2'd0, cyc, per, bad);
    checks++; if (data_out !== 16'hA5C3) begin failures++; $display("FAIL t1_data_out got=%h exp=a5c3", data_out); end
    checks++; if (cyc != 69) begin failures++; $display("FAIL t1_latency got=%0d exp=69", cyc); end
    checks++; if (bad != 0) begin failures++; $display("FAIL t1_ss_n_low got=%0d bad cycles exp=0", bad); end
    checks++; if (per != 4) begin failures++; $display("FAIL t1_sck_period got=%0d exp=4", per); end
    checks++; if (s_rx !== 16'hA5C3) begin failures++; $display("FAIL t1_mosi_stream got=%h exp=a5c3", s_rx); end
    repeat (3) @(posedge clk);
    #1;
    checks++; if (done_cnt - d0 != 1) begin failures++; $display("FAIL t1_done_once got=%0d exp=1", done_cnt - d0); end
  endtask

  task automatic test_modes;
    int cyc, per, bad;
    logic [1:0] md;
    loopback = 1'b0;
    for (int m = 0; m < 4; m++) begin
      md = modes[m];
      run_frame(words[m], 8'd1, md[1], md[0], 1'b0, 2'd0, cyc, per, bad);
      checks++; if (data_out !== 16'h3C5A) begin failures++; $display("FAIL mode%0d_master_rx got=%h exp=3c5a", m, data_out); end
      checks++; if (s_rx !== words[m]) begin failures++; $display("FAIL mode%0d_slave_rx got=%h exp=%h", m, s_rx, words[m]); end
      checks++; if (s_edges != 32) begin failures++; $display("FAIL mode%0d_sck_edges got=%0d exp=32", m, s_edges); end
      checks++; if (sck !== md[1]) begin failures++; $display("FAIL mode%0d_sck_idle got=%b exp=%b", m, sck, md[1]); end
    end
    loopback = 1'b1;
  endtask

  task automatic test_lsb_first;
    int cyc, per, bad;
    loopback = 1'b1;
    run_frame(16'h0001, 8'd1, 1'b0, 1'b0, 1'b1, 2'd0, cyc, per, bad);
    checks++; if (s_rx !== 16'h8000) begin failures++; $display("FAIL lsb_mosi_stream got=%h exp=8000", s_rx); end
    checks++; if (data_out !== 16'h0001) begin failures++; $display("FAIL lsb_data_out got=%h exp=0001", data_out); end
    run_frame(16'hA5C3, 8'd1, 1'b0, 1'b1, 1'b1, 2'd0, cyc, per, bad);
    checks++; if (s_rx !== 16'hC3A5) begin failures++; $display("FAIL lsb_mode1_stream got=%h exp=c3a5", s_rx); end
    checks++; if (data_out !== 16'hA5C3) begin failures++; $display("FAIL lsb_mode1_data_out got=%h exp=a5c3", data_out); end
  endtask

  task automatic test_back_to_back;
    int cyc, bad, d0;
    loopback = 1'b1;
    @(posedge clk); #1;
    data_in = 16'h5A5A; clk_div = 8'd0; cpol = 1'b0; cpha = 1'b0; lsb_first = 1'b0; ss_sel = 2'd2;
    sl_cpol = 1'b0; sl_cpha = 1'b0;
    @(posedge clk); #1;
    d0 = done_cnt; start = 1'b1; cyc = 0; bad = 0;
    while (cyc < 2000) begin
      @(posedge clk); #1;
      cyc++;
      if (done === 1'b1) break;
      if (ss_n !== 4'b1011 || busy !== 1'b1) bad++;
    end
    checks++; if (cyc != 35) begin failures++; $display("FAIL b2b_latency got=%0d exp=35", cyc); end
    checks++; if (bad != 0) begin failures++; $display("FAIL b2b_ss_busy got=%0d bad cycles exp=0", bad); end
    checks++; if (busy !== 1'b1) begin failures++; $display("FAIL b2b_busy_at_done got=%b exp=1", busy); end
    checks++; if (data_out !== 16'h5A5A) begin failures++; $display("FAIL b2b_data_out got=%h exp=5a5a", data_out); end
    @(posedge clk); #1;
    checks++; if (busy !== 1'b0 || ss_n !== 4'hF) begin failures++; $display("FAIL b2b_gap got busy=%b ss_n=%h exp busy=0 ss_n=f", busy, ss_n); end
    @(posedge clk); #1;
    checks++; if (busy !== 1'b1 || ss_n !== 4'b1011) begin failures++; $display("FAIL b2b_restart got busy=%b ss_n=%h exp busy=1 ss_n=b", busy, ss_n); end
    start = 1'b0;
    cyc = 0;
    while (cyc < 2000 && done !== 1'b1) begin
      @(posedge clk); #1;
      cyc++;
    end
    repeat (2) @(posedge clk);
    #1;
    checks++; if (done_cnt - d0 != 2) begin failures++; $display("FAIL b2b_frame_count got=%0d exp=2", done_cnt - d0); end
  endtask

  task automatic test_reset_abort;
    int cyc, per, bad, d0;
    loopback = 1'b1;
    @(posedge clk); #1;
    data_in = 16'h6B2D; clk_div = 8'd1; cpol = 1'b1; cpha = 1'b1; lsb_first = 1'b0; ss_sel = 2'd0;
    sl_cpol = 1'b1; sl_cpha = 1'b1;
    @(posedge clk); #1;
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    cyc = 0;
    while (cyc < 500 && s_edges < 10) begin
      @(posedge clk); #1;
      cyc++;
    end
    checks++; if (s_edges < 10) begin failures++; $display("FAIL abort_reach_edge10 got=%0d exp>=10", s_edges); end
    d0 = done_cnt;
    #2 rst = 1'b0;
    #1;
    checks++; if (ss_n !== 4'hF) begin failures++; $display("FAIL abort_ss_n got=%h exp=f", ss_n); end
    checks++; if (sck !== 1'b0) begin failures++; $display("FAIL abort_sck got=%b exp=0", sck); end
    checks++; if (busy !== 1'b0) begin failures++; $display("FAIL abort_busy got=%b exp=0", busy); end
    checks++; if (data_out !== 16'h0) begin failures++; $display("FAIL abort_data_out got=%h exp=0000", data_out); end
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    checks++; if (done_cnt != d0) begin failures++; $display("FAIL abort_no_done got=%0d exp=%0d", done_cnt, d0); end
    run_frame(16'hC33C, 8'd1, 1'b1, 1'b1, 1'b0, 2'd0, cyc, per, bad);
    checks++; if (data_out !== 16'hC33C) begin failures++; $display("FAIL abort_next_frame got=%h exp=c33c", data_out); end
    checks++; if (cyc != 69) begin failures++; $display("FAIL abort_next_latency got=%0d exp=69", cyc); end
  endtask

  task automatic test_divider_extremes;
    int cyc, per, bad;
    loopback = 1'b1;
    run_frame(16'hE71B, 8'd0, 1'b0, 1'b0, 1'b0, 2'd0, cyc, per, bad);
    checks++; if (per != 2) begin failures++; $display("FAIL div0_period got=%0d exp=2", per); end
    checks++; if (data_out !== 16'hE71B) begin failures++; $display("FAIL div0_data_out got=%h exp=e71b", data_out); end
    run_frame(16'h0FF0, 8'd255, 1'b0, 1'b1, 1'b0, 2'd0, cyc, per, bad);
    checks++; if (per != 512) begin failures++; $display("FAIL div255_period got=%0d exp=512", per); end
    checks++; if (data_out !== 16'h0FF0) begin failures++; $display("FAIL div255_data_out got=%h exp=0ff0", data_out); end
    checks++; if (cyc != 8705) begin failures++; $display("FAIL div255_latency got=%0d exp=8705", cyc); end
  endtask

  initial begin
    test_reset();
    test_mode0_loopback();
    test_modes();
    test_lsb_first();
    test_back_to_back();
    test_reset_abort();
    test_divider_extremes();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
